ga_sync_int: RTL and testbench
==============================

Name: ga_sync_int

Overview:
- Gate-array side consumer of the CRTC's HSYNC/VSYNC outputs.
- Produces monitor sync: a delayed, width-limited HSYNC and a delayed, fixed-length VSYNC.
- Runs the CPC raster interrupt counter (R52): Z80 interrupt every 52 lines, VSYNC resynchronisation, and the acknowledge/clear rules.
- Sits between the CRTC and the Z80 interrupt line / video output stage, and runs on the same char-rate CLKEN as the CRTC.

Parameters:
- INT_LINES, 52, HSYNC count that raises INT and wraps R52.
- HS_DELAY, 2, CLKEN ticks from HSYNC_IN rise to HSYNC_OUT rise.
- HS_WIDTH, 4, maximum HSYNC_OUT width in CLKEN ticks.
- VS_DELAY, 2, HSYNC_IN falling edges from VSYNC_IN rise to VSYNC_OUT rise.
- VS_WIDTH, 4, VSYNC_OUT width in HSYNC_IN falling edges.

Ports:
- CLOCK, in, 1, system clock.
- RESET, in, 1, synchronous reset, active-high.
- CLKEN, in, 1, char-rate enable (1 MHz), same strobe as the CRTC.
- HSYNC_IN, in, 1, CRTC HSYNC.
- VSYNC_IN, in, 1, CRTC VSYNC.
- INT_ACK, in, 1, one-CLOCK pulse on Z80 interrupt acknowledge (M1 & IORQ).
- INT_CLR, in, 1, one-CLOCK pulse on gate-array write of the RMR register with bit 4 set.
- INT, out, 1, Z80 interrupt request, active-high, level.
- HSYNC_OUT, out, 1, monitor HSYNC.
- VSYNC_OUT, out, 1, monitor VSYNC.
- MODE_LATCH, out, 1, one-CLKEN-tick pulse coinciding with HSYNC_OUT rise; the gate array loads the pending screen mode on it.
- R52, out, 6, interrupt line counter, for debug/status.

Behaviour:
- All state updates only on CLOCK edges with CLKEN=1, except INT_ACK/INT_CLR, which act on any CLOCK edge.
- RESET has priority over everything.
- RESET values: INT=0, HSYNC_OUT=0, VSYNC_OUT=0, MODE_LATCH=0, R52=0. All internal counters and edge registers are 0.
- Edge detect: hs_d/vs_d are sampled each CLKEN.
  - hs_rise = HSYNC_IN & ~hs_d; hs_fall = ~HSYNC_IN & hs_d; vs_rise likewise.
- HSYNC path (hsd counter, 0..HS_DELAY+HS_WIDTH):
  - On hs_rise, hsd is loaded with 1 and increments while HSYNC_IN=1.
  - HSYNC_OUT=1 while HS_DELAY < hsd ≤ HS_DELAY+HS_WIDTH and HSYNC_IN=1.
  - Result: HSYNC_IN width w gives HSYNC_OUT width max(0, min(w−HS_DELAY, HS_WIDTH)) ticks, starting HS_DELAY ticks after the rise.
  - hsd saturates; HSYNC_IN low clears it.
- MODE_LATCH pulses for one CLKEN tick on HSYNC_OUT 0→1.
- R52 on hs_fall (evaluated in this priority):
  - VSYNC resync pending and this is the VS_DELAY-th hs_fall since vs_rise: if R52 ≥ 32, set INT=1. Then R52←0.
  - Else if R52+1 == INT_LINES: R52←0, INT←1.
  - Else R52←R52+1 (6-bit).
- VSYNC: vs_rise arms vcnt=0 and sets resync pending.
  - Each hs_fall increments vcnt.
  - At vcnt reaching VS_DELAY: VSYNC_OUT←1 and pending cleared.
  - VSYNC_OUT drops at the hs_fall that completes VS_WIDTH further lines, or at any hs_fall seen with VSYNC_IN=0 after the VS_DELAY point, whichever comes first.
  - vs_rise while VSYNC_OUT=1 re-arms the sequence; VSYNC_OUT stays 1 until the new sequence ends.
- INT_ACK: INT←0, R52←R52 & 6'h1F.
- INT_CLR: INT←0, R52←0.
- Simultaneous events in one cycle:
  - INT_CLR beats all.
  - A set of INT from R52/VSYNC beats INT_ACK; INT stays 1, R52←0.
  - An hs_fall coinciding with INT_ACK applies the ACK mask to the pre-increment value, then the increment.
- No combinational input→output paths; all outputs are registered.

Decomposition:
- Shared package holds the GA timing constants (INT_LINES, HS_DELAY, HS_WIDTH, VS_DELAY, VS_WIDTH) for use by the gate array top, and a 6-bit r52_t type.
- One natural sub-module, ga_sync_edge: CLKEN-qualified rise/fall detector, instantiated for HSYNC_IN and VSYNC_IN.

Test Plan:
- Reset mid-frame with INT=1, R52=40 → next cycle INT=0, R52=0, HSYNC_OUT=0, VSYNC_OUT=0.
- HSYNC_IN width 14 ticks, period 64 → HSYNC_OUT rises 2 ticks after HSYNC_IN, lasts 4 ticks; MODE_LATCH one-tick pulse on that rise. Width 5 → HSYNC_OUT 3 ticks. Width 2 → no HSYNC_OUT.
- 52 HSYNC_IN pulses, no VSYNC → INT rises at the 52nd fall, R52=0; INT_ACK 10 lines later → INT=0, R52=10.
- VSYNC_IN rise at R52=35 → 2 hs_falls later INT=1, R52=0; VSYNC_OUT high from the 2nd to the 6th hs_fall (4 lines). Same at R52=20 → no INT, R52=0.
- INT_ACK with R52=45 and no pending INT → R52=13, INT=0. INT_ACK in the same cycle as the 52nd hs_fall → INT=1, R52=0.
- INT_CLR in the same cycle as an INT set → INT=0, R52=0. VSYNC_IN width 2 lines → VSYNC_OUT ends at the first hs_fall with VSYNC_IN=0 after it rose.

Source files
------------

// File: rtl/ga_sync_int_pkg.sv
// Shared gate-array sync timing constants and types.
// Used by the raster interrupt counter and monitor sync generator.
package ga_sync_int_pkg;

  localparam int INT_LINES = 52;
  localparam int HS_DELAY  = 2;
  localparam int HS_WIDTH  = 4;
  localparam int VS_DELAY  = 2;
  localparam int VS_WIDTH  = 4;

  typedef logic [5:0] r52_t;
  typedef logic [3:0] hsd_t;
  typedef logic [2:0] vcnt_t;

  // hsd runs one past the pulse window so a long HSYNC_IN parks outside it
  localparam hsd_t  HSD_ON_MIN     = hsd_t'(HS_DELAY);
  localparam hsd_t  HSD_MAX        = hsd_t'(HS_DELAY + HS_WIDTH + 1);
  localparam r52_t  R52_WRAP       = r52_t'(INT_LINES - 1);
  localparam r52_t  R52_RESYNC_MIN = 6'd32;
  localparam vcnt_t VCNT_ON        = vcnt_t'(VS_DELAY);
  localparam vcnt_t VCNT_OFF       = vcnt_t'(VS_DELAY + VS_WIDTH);

  function automatic r52_t r52_ack_mask(input r52_t v);
    return v & 6'h1F;
  endfunction

endpackage

// File: rtl/ga_sync_int_if.sv
// CRTC/CPU-facing signal bundle of the gate-array sync/interrupt block.
interface ga_sync_int_if;
  import ga_sync_int_pkg::*;

  logic CLKEN;
  logic HSYNC_IN;
  logic VSYNC_IN;
  logic INT_ACK;
  logic INT_CLR;
  logic INT;
  logic HSYNC_OUT;
  logic VSYNC_OUT;
  logic MODE_LATCH;
  r52_t R52;

  modport master (
    output CLKEN, HSYNC_IN, VSYNC_IN, INT_ACK, INT_CLR,
    input  INT, HSYNC_OUT, VSYNC_OUT, MODE_LATCH, R52
  );

  modport slave (
    input  CLKEN, HSYNC_IN, VSYNC_IN, INT_ACK, INT_CLR,
    output INT, HSYNC_OUT, VSYNC_OUT, MODE_LATCH, R52
  );

endinterface

// File: rtl/ga_sync_int_edge.sv
// CLKEN-qualified rise/fall detector for a CRTC sync line.
module ga_sync_edge (
  input  logic CLOCK,
  input  logic RESET,
  input  logic CLKEN,
  input  logic sig,
  output logic rise_s,
  output logic fall_s
);

  logic d_r;

  // Remember the level seen at the previous char tick
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      d_r <= 1'b0;
    end else if (CLKEN) begin
      d_r <= sig;
    end else begin
      d_r <= d_r;
    end
  end

  assign rise_s = CLKEN & sig & ~d_r;
  assign fall_s = CLKEN & ~sig & d_r;

endmodule

// File: rtl/ga_sync_int.sv
// Gate-array sync consumer: monitor HSYNC/VSYNC shaping, MODE_LATCH strobe
// and the 52-line raster interrupt counter with VSYNC resynchronisation.
module ga_sync_int
  import ga_sync_int_pkg::*;
(
  input logic         CLOCK,
  input logic         RESET,
  ga_sync_int_if.slave bus
);

  logic  hs_rise_s;
  logic  hs_fall_s;
  logic  vs_rise_s;
  logic  vs_fall_s;

  hsd_t  hsd_r;
  hsd_t  hsd_nxt_s;
  logic  hs_on_s;
  logic  hs_out_r;
  logic  mode_latch_r;

  vcnt_t vcnt_r;
  vcnt_t vcnt_inc_s;
  logic  vact_r;
  logic  pend_r;
  logic  vs_out_r;
  logic  vs_low_s;
  logic  resync_s;

  r52_t  r52_r;
  r52_t  r52_base_s;
  r52_t  r52_nxt_s;
  logic  wrap_s;
  logic  int_set_s;
  logic  int_r;
  logic  int_nxt_s;

  ga_sync_edge u_hs_edge (
    .CLOCK  (CLOCK),
    .RESET  (RESET),
    .CLKEN  (bus.CLKEN),
    .sig    (bus.HSYNC_IN),
    .rise_s (hs_rise_s),
    .fall_s (hs_fall_s)
  );

  ga_sync_edge u_vs_edge (
    .CLOCK  (CLOCK),
    .RESET  (RESET),
    .CLKEN  (bus.CLKEN),
    .sig    (bus.VSYNC_IN),
    .rise_s (vs_rise_s),
    .fall_s (vs_fall_s)
  );

  // Next HSYNC delay count and whether the monitor pulse is inside its window
  always_comb begin
    hsd_nxt_s = hsd_r;
    if (!bus.HSYNC_IN) begin
      hsd_nxt_s = '0;
    end else if (hs_rise_s) begin
      hsd_nxt_s = 4'd1;
    end else if (hsd_r != HSD_MAX) begin
      hsd_nxt_s = hsd_r + 4'd1;
    end else begin
      hsd_nxt_s = hsd_r;
    end
    hs_on_s = bus.HSYNC_IN & (hsd_nxt_s > HSD_ON_MIN) & (hsd_nxt_s < HSD_MAX);
  end

  // HSYNC delay counter, monitor HSYNC and the mode-latch strobe
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      hsd_r        <= '0;
      hs_out_r     <= 1'b0;
      mode_latch_r <= 1'b0;
    end else if (bus.CLKEN) begin
      hsd_r        <= hsd_nxt_s;
      hs_out_r     <= hs_on_s;
      mode_latch_r <= hs_on_s & ~hs_out_r;
    end else begin
      hsd_r        <= hsd_r;
      hs_out_r     <= hs_out_r;
      mode_latch_r <= mode_latch_r;
    end
  end

  // VSYNC sequencing terms; a fresh VSYNC rise restarts the count
  always_comb begin
    vcnt_inc_s = vcnt_r + 3'd1;
    vs_low_s   = ~bus.VSYNC_IN | vs_fall_s;
    resync_s   = hs_fall_s & ~vs_rise_s & vact_r & pend_r & (vcnt_inc_s == VCNT_ON);
  end

  // VSYNC line counter, resync pending flag and monitor VSYNC
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      vcnt_r   <= '0;
      vact_r   <= 1'b0;
      pend_r   <= 1'b0;
      vs_out_r <= 1'b0;
    end else if (vs_rise_s) begin
      vcnt_r   <= '0;
      vact_r   <= 1'b1;
      pend_r   <= 1'b1;
    end else if (hs_fall_s && vact_r) begin
      vcnt_r <= vcnt_inc_s;
      if (vcnt_inc_s == VCNT_ON) begin
        vs_out_r <= 1'b1;
        pend_r   <= 1'b0;
      end else if ((vcnt_inc_s > VCNT_ON) && ((vcnt_inc_s == VCNT_OFF) || vs_low_s)) begin
        vs_out_r <= 1'b0;
        vact_r   <= 1'b0;
      end else begin
        vs_out_r <= vs_out_r;
      end
    end else begin
      vcnt_r <= vcnt_r;
    end
  end

  // Interrupt counter next state; a set from the counter outranks an ACK
  always_comb begin
    r52_base_s = bus.INT_ACK ? r52_ack_mask(r52_r) : r52_r;
    wrap_s     = hs_fall_s & ~resync_s & (r52_r == R52_WRAP);
    int_set_s  = (resync_s & (r52_r >= R52_RESYNC_MIN)) | wrap_s;
    r52_nxt_s  = r52_r;
    int_nxt_s  = int_r;
    if (bus.INT_CLR) begin
      r52_nxt_s = '0;
      int_nxt_s = 1'b0;
    end else if (resync_s || wrap_s) begin
      r52_nxt_s = '0;
      int_nxt_s = int_set_s | (int_r & ~bus.INT_ACK);
    end else if (hs_fall_s) begin
      r52_nxt_s = r52_base_s + 6'd1;
      int_nxt_s = int_r & ~bus.INT_ACK;
    end else begin
      r52_nxt_s = r52_base_s;
      int_nxt_s = int_r & ~bus.INT_ACK;
    end
  end

  // Interrupt counter and request; ACK/CLR act on every CLOCK edge
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r52_r <= '0;
      int_r <= 1'b0;
    end else begin
      r52_r <= r52_nxt_s;
      int_r <= int_nxt_s;
    end
  end

  assign bus.INT        = int_r;
  assign bus.HSYNC_OUT  = hs_out_r;
  assign bus.VSYNC_OUT  = vs_out_r;
  assign bus.MODE_LATCH = mode_latch_r;
  assign bus.R52        = r52_r;

endmodule

// File: tb/tb_ga_sync_int.sv
// Directed plus randomized bench for ga_sync_int against a line-level model.
module tb_ga_sync_int;
  import ga_sync_int_pkg::*;

  logic CLOCK = 1'b0;
  logic RESET;

  ga_sync_int_if bus ();

  ga_sync_int dut (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLOCK = ~CLOCK;

  int errors = 0;
  int checks = 0;

  // model state
  int m_int, m_r52, m_hs_out, m_ml, m_vs_out;
  int m_hs_prev, m_vs_prev, m_hs_ticks, m_vs_lines, m_pend;
  int hs_hi_cnt, ml_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_step();
    bit ce, hs, vs, fall, vrise, resync, set;
    ce = bus.CLKEN; hs = bus.HSYNC_IN; vs = bus.VSYNC_IN;
    if (RESET) begin
      m_int = 0; m_r52 = 0; m_hs_out = 0; m_ml = 0; m_vs_out = 0;
      m_hs_prev = 0; m_vs_prev = 0; m_hs_ticks = 0; m_vs_lines = -1; m_pend = 0;
      return;
    end
    fall   = ce && !hs && (m_hs_prev != 0);
    vrise  = ce && vs && (m_vs_prev == 0);
    resync = 0;
    set    = 0;
    if (ce) begin
      // ticks since HSYNC_IN rose: pulse occupies ticks [HS_DELAY, HS_DELAY+HS_WIDTH)
      m_hs_ticks = hs ? ((m_hs_prev != 0) ? m_hs_ticks + 1 : 0) : 0;
      m_hs_out   = (hs && m_hs_ticks >= HS_DELAY && m_hs_ticks < HS_DELAY + HS_WIDTH) ? 1 : 0;
      m_ml       = (hs && m_hs_ticks == HS_DELAY) ? 1 : 0;
      m_hs_prev  = hs;
      m_vs_prev  = vs;
    end
    if (vrise) begin
      m_vs_lines = 0;
      m_pend     = 1;
    end else if (fall && m_vs_lines >= 0) begin
      m_vs_lines++;
      if (m_vs_lines == VS_DELAY) begin
        m_vs_out = 1;
        resync   = (m_pend != 0);
        m_pend   = 0;
      end else if (m_vs_lines > VS_DELAY && (m_vs_lines == VS_DELAY + VS_WIDTH || !vs)) begin
        m_vs_out   = 0;
        m_vs_lines = -1;
      end
    end
    if (bus.INT_CLR) begin
      m_int = 0;
      m_r52 = 0;
    end else begin
      if (fall) begin
        if (resync) begin
          set   = (m_r52 >= 32);
          m_r52 = 0;
        end else if (m_r52 + 1 == INT_LINES) begin
          set   = 1;
          m_r52 = 0;
        end else begin
          m_r52 = ((bus.INT_ACK ? m_r52 % 32 : m_r52) + 1) % 64;
        end
      end else if (bus.INT_ACK) begin
        m_r52 = m_r52 % 32;
      end
      if (set) m_int = 1;
      else if (bus.INT_ACK) m_int = 0;
    end
  endtask

  task automatic cyc(input logic ce);
    bus.CLKEN = ce;
    @(posedge CLOCK);
    model_step();
    #1;
    chk("INT",        {31'd0, bus.INT},        m_int);
    chk("R52",        {26'd0, bus.R52},        m_r52);
    chk("HSYNC_OUT",  {31'd0, bus.HSYNC_OUT},  m_hs_out);
    chk("MODE_LATCH", {31'd0, bus.MODE_LATCH}, m_ml);
    chk("VSYNC_OUT",  {31'd0, bus.VSYNC_OUT},  m_vs_out);
    if (ce && bus.HSYNC_OUT === 1'b1) hs_hi_cnt++;
    if (ce && bus.MODE_LATCH === 1'b1) ml_cnt++;
    @(negedge CLOCK);
    bus.INT_ACK = 1'b0;
    bus.INT_CLR = 1'b0;
  endtask

  task automatic tick(input bit ack, input bit clr);
    bus.INT_ACK = ack;
    bus.INT_CLR = clr;
    cyc(1'b1);
    cyc(1'b0);
  endtask

  task automatic line(input int w, input int period, input int ack_at, input int clr_at);
    for (int t = 0; t < period; t++) begin
      bus.HSYNC_IN = (t < w);
      tick(t == ack_at, t == clr_at);
    end
  endtask

  task automatic lines(input int n);
    for (int i = 0; i < n; i++) line(4, 12, -1, -1);
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    cyc(1'b1);
    RESET = 1'b0;
    cyc(1'b0);
  endtask

  task automatic hs_width(input int w, input int exp_hi, input int exp_ml);
    hs_hi_cnt = 0;
    ml_cnt    = 0;
    line(w, 64, -1, -1);
    chk($sformatf("hs_w%0d_width", w), hs_hi_cnt, exp_hi);
    chk($sformatf("hs_w%0d_mlatch", w), ml_cnt, exp_ml);
  endtask

  initial begin
    int vs_left, w, ack_at, clr_at;
    bus.CLKEN = 1'b0; bus.HSYNC_IN = 1'b0; bus.VSYNC_IN = 1'b0;
    bus.INT_ACK = 1'b0; bus.INT_CLR = 1'b0;
    hs_hi_cnt = 0; ml_cnt = 0;
    do_reset();

    // HSYNC shaping at widths 14, 5 and 2
    hs_width(14, 4, 1);
    hs_width(5, 3, 1);
    hs_width(2, 0, 0);
    chk("r52_three_lines", bus.R52, 3);

    // 52-line interrupt, then reset with INT=1 and R52=40
    do_reset();
    lines(51);
    chk("int_before_52", bus.INT, 0);
    chk("r52_at_51", bus.R52, 51);
    lines(1);
    chk("int_at_52", bus.INT, 1);
    chk("r52_wrap", bus.R52, 0);
    lines(40);
    chk("r52_at_40", bus.R52, 40);
    do_reset();
    chk("rst_int", bus.INT, 0);
    chk("rst_r52", bus.R52, 0);
    chk("rst_hsync", bus.HSYNC_OUT, 0);
    chk("rst_vsync", bus.VSYNC_OUT, 0);

    // ACK ten lines after the interrupt
    lines(52);
    lines(10);
    chk("int_held", bus.INT, 1);
    bus.INT_ACK = 1'b1;
    cyc(1'b0);
    chk("ack10_int", bus.INT, 0);
    chk("ack10_r52", bus.R52, 10);

    // VSYNC resync at R52=35
    do_reset();
    lines(35);
    bus.VSYNC_IN = 1'b1;
    lines(1);
    chk("vs35_l1_vsync", bus.VSYNC_OUT, 0);
    chk("vs35_l1_r52", bus.R52, 36);
    lines(1);
    chk("vs35_int", bus.INT, 1);
    chk("vs35_r52", bus.R52, 0);
    chk("vs35_vsync_on", bus.VSYNC_OUT, 1);
    lines(3);
    chk("vs35_vsync_5", bus.VSYNC_OUT, 1);
    lines(1);
    chk("vs35_vsync_off", bus.VSYNC_OUT, 0);
    chk("vs35_r52_after", bus.R52, 4);
    bus.VSYNC_IN = 1'b0;

    // VSYNC resync at R52=20: no interrupt
    do_reset();
    lines(20);
    bus.VSYNC_IN = 1'b1;
    lines(2);
    chk("vs20_int", bus.INT, 0);
    chk("vs20_r52", bus.R52, 0);
    lines(4);
    bus.VSYNC_IN = 1'b0;

    // ACK mask with no pending interrupt
    do_reset();
    lines(45);
    bus.INT_ACK = 1'b1;
    cyc(1'b0);
    chk("ack45_r52", bus.R52, 13);
    chk("ack45_int", bus.INT, 0);

    // ACK coinciding with the 52nd HSYNC fall
    do_reset();
    lines(51);
    line(4, 12, 4, -1);
    chk("ack52_int", bus.INT, 1);
    chk("ack52_r52", bus.R52, 0);

    // CLR coinciding with an interrupt set
    do_reset();
    lines(51);
    line(4, 12, -1, 4);
    chk("clr52_int", bus.INT, 0);
    chk("clr52_r52", bus.R52, 0);

    // Short VSYNC_IN ends VSYNC_OUT early
    do_reset();
    bus.VSYNC_IN = 1'b1;
    lines(2);
    chk("vs2_on", bus.VSYNC_OUT, 1);
    bus.VSYNC_IN = 1'b0;
    lines(1);
    chk("vs2_off", bus.VSYNC_OUT, 0);

    // Randomized lines, VSYNC bursts, ACK and CLR pulses
    do_reset();
    vs_left = 0;
    for (int n = 0; n < 220; n++) begin
      w = int'($urandom_range(0, 9));
      if (vs_left == 0 && $urandom_range(0, 11) == 0) vs_left = int'($urandom_range(1, 8));
      bus.VSYNC_IN = (vs_left > 0);
      ack_at = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 11)) : -1;
      clr_at = ($urandom_range(0, 39) == 0) ? int'($urandom_range(0, 11)) : -1;
      line(w, 12, ack_at, clr_at);
      if (vs_left > 0) vs_left--;
      if ($urandom_range(0, 9) == 0) begin
        bus.INT_ACK = 1'b1;
        cyc(1'b0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
